// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 window generator with two line buffers
// Emits WIDTH*HEIGHT raster-order windows per frame; edge-centred windows are zeroed.
module window_gen_3x3 #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int BITW   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [BITW-1:0]           in_pixel,
  output logic                      in_ready,
  output logic                      win_valid,
  output logic                      border,
  output logic [BITW-1:0]           u00,
  output logic [BITW-1:0]           u01,
  output logic [BITW-1:0]           u02,
  output logic [BITW-1:0]           u10,
  output logic [BITW-1:0]           u11,
  output logic [BITW-1:0]           u12,
  output logic [BITW-1:0]           u20,
  output logic [BITW-1:0]           u21,
  output logic [BITW-1:0]           u22,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic                      frame_done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d, oc_col_q, oc_col_d, out_col_q, out_col_d;
  logic [RW-1:0]   in_row_q, in_row_d, oc_row_q, oc_row_d, out_row_q, out_row_d;
  logic            in_ready_q, in_ready_d, win_valid_q, win_valid_d;
  logic            border_q, border_d, frame_done_q, frame_done_d;
  logic [BITW-1:0] win_q [3][3];
  logic [BITW-1:0] win_d [3][3];
  logic [BITW-1:0] lb1 [WIDTH];
  logic [BITW-1:0] lb2 [WIDTH];
  logic            accept, emit, in_last_col, in_last_row, oc_last, show;
  logic [BITW-1:0] top, mid;

  assign accept      = in_valid & in_ready_q;
  assign in_last_col = (in_col_q == COL_LAST);
  assign in_last_row = (in_row_q == ROW_LAST);
  assign oc_last     = (oc_row_q == ROW_LAST) && (oc_col_q == COL_LAST);
  assign top         = lb2[in_col_q];
  assign mid         = lb1[in_col_q];

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    oc_col_d = oc_col_q;
    oc_row_d = oc_row_q;
    win_d    = win_q;
    emit     = 1'b0;
    if (accept) begin
      in_col_d = in_last_col ? '0 : in_col_q + CW'(1);
      in_row_d = !in_last_col ? in_row_q : (in_last_row ? '0 : in_row_q + RW'(1));
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top;
      win_d[1][2] = mid;
      win_d[2][2] = in_pixel;
    end
    case (state_q)
      FILL:  if (accept && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
      RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (in_last_col && in_last_row) state_d = FLUSH;
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (oc_last) begin
          state_d  = FILL;
          in_col_d = '0;
          in_row_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
    // oc_* holds the centre of the next window to be emitted
    if (emit) begin
      oc_col_d = (oc_col_q == COL_LAST) ? '0 : oc_col_q + CW'(1);
      if (oc_col_q == COL_LAST) oc_row_d = (oc_row_q == ROW_LAST) ? '0 : oc_row_q + RW'(1);
    end
    border_d     = emit & ((oc_row_q == '0) | (oc_row_q == ROW_LAST) |
                           (oc_col_q == '0) | (oc_col_q == COL_LAST));
    win_valid_d  = emit;
    frame_done_d = emit & oc_last;
    out_row_d    = emit ? oc_row_q : out_row_q;
    out_col_d    = emit ? oc_col_q : out_col_q;
    in_ready_d   = (state_d != FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      in_col_q     <= '0;
      in_row_q     <= '0;
      oc_col_q     <= '0;
      oc_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      in_ready_q   <= 1'b1;
      win_valid_q  <= 1'b0;
      border_q     <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      oc_col_q     <= oc_col_d;
      oc_row_q     <= oc_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      in_ready_q   <= in_ready_d;
      win_valid_q  <= win_valid_d;
      border_q     <= border_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers are plain storage; stale contents only reach masked border windows
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[in_col_q] <= lb1[in_col_q];
      lb1[in_col_q] <= in_pixel;
    end
  end

  assign show       = win_valid_q & ~border_q;
  assign u00        = show ? win_q[0][0] : '0;
  assign u01        = show ? win_q[0][1] : '0;
  assign u02        = show ? win_q[0][2] : '0;
  assign u10        = show ? win_q[1][0] : '0;
  assign u11        = show ? win_q[1][1] : '0;
  assign u12        = show ? win_q[1][2] : '0;
  assign u20        = show ? win_q[2][0] : '0;
  assign u21        = show ? win_q[2][1] : '0;
  assign u22        = show ? win_q[2][2] : '0;
  assign in_ready   = in_ready_q;
  assign win_valid  = win_valid_q;
  assign border     = border_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - self-checking bench for window_gen_3x3 on 8x8 frames
// Reference windows are computed directly from the frame image array.
module tb_window_gen_3x3;
  localparam int W = 8;
  localparam int H = 8;

  logic       clk, rst_n, in_valid, in_ready, win_valid, border, frame_done;
  logic [7:0] in_pixel, u00, u01, u02, u10, u11, u12, u20, u21, u22;
  logic [2:0] out_row, out_col;

  window_gen_3x3 #(.WIDTH(W), .HEIGHT(H), .BITW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .win_valid(win_valid), .border(border),
    .u00(u00), .u01(u01), .u02(u02), .u10(u10), .u11(u11), .u12(u12),
    .u20(u20), .u21(u21), .u22(u22),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         r;
    int         c;
    bit         b;
    logic [71:0] u;
  } vec_t;

  int            pass_cnt = 0;
  int            tot_cnt  = 0;
  logic [7:0]    img [W*H];
  logic [127:0]  obs[$];
  logic [127:0]  ramp_obs[$];
  int            acc_cnt, first_acc, lo_cnt, bad_timing;
  bit            fd_seen, prev_hs, prev_rdy;
  vec_t          tbl [8];

  function automatic logic [127:0] pk(input int r, input int c, input bit b, input bit fd,
                                      input logic [71:0] u);
    return {46'd0, r[3:0], c[3:0], b, fd, u};
  endfunction

  function automatic logic [127:0] exp_win(input int k);
    int          r = k / W;
    int          c = k % W;
    bit          b = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    logic [71:0] u = '0;
    if (!b)
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          u = {u[63:0], img[(r - 1 + dr) * W + (c - 1 + dc)]};
    return pk(r, c, b, k == W * H - 1, u);
  endfunction

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] expv);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs  = 1'b0;
      prev_rdy = 1'b1;
    end else begin
      if (win_valid) begin
        obs.push_back(pk(int'(out_row), int'(out_col), border, frame_done,
                         {u00, u01, u02, u10, u11, u12, u20, u21, u22}));
        if (obs.size() == 1) first_acc = acc_cnt;
        if (!(prev_hs || !prev_rdy)) bad_timing++;
        if (frame_done) fd_seen = 1'b1;
      end
      if (!in_ready) lo_cnt++;
      prev_hs  = in_valid && in_ready;
      prev_rdy = in_ready;
      if (prev_hs) acc_cnt++;
    end
  end

  task automatic start_frame();
    obs.delete();
    fd_seen    = 1'b0;
    lo_cnt     = 0;
    acc_cnt    = 0;
    bad_timing = 0;
    first_acc  = -1;
  endtask

  task automatic send(input int n_pix, input int bubble_pct);
    int i = 0;
    int guard = 0;
    while (i < n_pix && guard < 5000) begin
      in_pixel = img[i];
      in_valid = ($urandom_range(0, 99) >= bubble_pct);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    chk(i == n_pix, "send_count", 128'(i), 128'(n_pix));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!fd_seen && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(fd_seen, "frame_done_timeout", 128'(fd_seen), 128'(1));
  endtask

  task automatic check_frame(input string tag);
    logic [127:0] e;
    chk(obs.size() == W * H, {tag, "_count"}, 128'(obs.size()), 128'(W * H));
    for (int k = 0; k < W * H && k < obs.size(); k++) begin
      e = exp_win(k);
      chk(obs[k] == e, $sformatf("%s_win%0d", tag, k), obs[k], e);
    end
    chk(bad_timing == 0, {tag, "_win_timing"}, 128'(bad_timing), 128'(0));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < W * H; i++) img[i] = 8'(i);
  endtask

  initial begin
    logic [127:0] got;
    int           idx;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pixel = 8'd0;
    tbl[0] = '{r: 0, c: 0, b: 1'b1, u: 72'h0};
    tbl[1] = '{r: 1, c: 1, b: 1'b0, u: {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18}};
    tbl[2] = '{r: 3, c: 4, b: 1'b0, u: {8'd19, 8'd20, 8'd21, 8'd27, 8'd28, 8'd29, 8'd35, 8'd36, 8'd37}};
    tbl[3] = '{r: 6, c: 6, b: 1'b0, u: {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63}};
    tbl[4] = '{r: 6, c: 1, b: 1'b0, u: {8'd40, 8'd41, 8'd42, 8'd48, 8'd49, 8'd50, 8'd56, 8'd57, 8'd58}};
    tbl[5] = '{r: 7, c: 7, b: 1'b1, u: 72'h0};
    tbl[6] = '{r: 0, c: 3, b: 1'b1, u: 72'h0};
    tbl[7] = '{r: 4, c: 0, b: 1'b1, u: 72'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", 128'(in_ready), 128'(1));
    chk(win_valid == 1'b0, "rst_win_valid", 128'(win_valid), 128'(0));
    chk(border == 1'b0, "rst_border", 128'(border), 128'(0));
    chk({u00, u01, u02, u10, u11, u12, u20, u21, u22} == 72'h0, "rst_u",
        128'({u00, u01, u02, u10, u11, u12, u20, u21, u22}), 128'(0));
    chk({out_row, out_col} == 6'd0, "rst_out_pos", 128'({out_row, out_col}), 128'(0));
    chk(frame_done == 1'b0, "rst_frame_done", 128'(frame_done), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // continuous ramp
    fill_ramp();
    start_frame();
    send(W * H, 0);
    wait_done();
    check_frame("ramp");
    chk(first_acc == W + 2, "first_win_latency", 128'(first_acc), 128'(W + 2));
    chk(lo_cnt == W + 1, "flush_ready_low", 128'(lo_cnt), 128'(W + 1));
    ramp_obs = obs;
    for (int t = 0; t < 8; t++) begin
      idx = tbl[t].r * W + tbl[t].c;
      got = (idx < ramp_obs.size()) ? ramp_obs[idx] : '0;
      chk({got[81:73], got[71:0]} == {tbl[t].r[3:0], tbl[t].c[3:0], tbl[t].b, tbl[t].u},
          $sformatf("table_%0d_%0d", tbl[t].r, tbl[t].c), got,
          pk(tbl[t].r, tbl[t].c, tbl[t].b, got[72], tbl[t].u));
    end

    // ramp with 50% bubbles
    start_frame();
    send(W * H, 50);
    wait_done();
    check_frame("ramp_bubbles");
    chk(obs == ramp_obs, "bubbles_vs_continuous", 128'(obs.size()), 128'(ramp_obs.size()));

    // random pixels with bubbles
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    start_frame();
    send(W * H, 50);
    wait_done();
    check_frame("random");

    // back-to-back ramp then all 0xFF
    fill_ramp();
    start_frame();
    send(W * H, 0);
    wait_done();
    check_frame("b2b_ramp");
    for (int i = 0; i < W * H; i++) img[i] = 8'hFF;
    start_frame();
    send(W * H, 0);
    wait_done();
    check_frame("b2b_ff");

    // reset mid-frame after 30 pixels, then a clean ramp
    fill_ramp();
    start_frame();
    send(30, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk(!win_valid && in_ready && {out_row, out_col} == 6'd0, "rst_mid_outputs",
        128'({win_valid, in_ready, out_row, out_col}), 128'({1'b0, 1'b1, 6'd0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame();
    send(W * H, 0);
    wait_done();
    check_frame("after_reset");
    chk(obs == ramp_obs, "reset_vs_clean", 128'(obs.size()), 128'(ramp_obs.size()));
    chk(first_acc == W + 2, "reset_first_latency", 128'(first_acc), 128'(W + 2));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 window generator that sits directly upstream of `conv3x3_comb`. It accepts one raster-order pixel per cycle, keeps the two previous image rows in internal line buffers, and presents a 3x3 neighbourhood on `u00..u22` for every output pixel position. Each window carries a `border` flag so the downstream path writes 0 at image edges. It emits exactly WIDTH*HEIGHT windows per frame, in raster order of the window centre.

## Interface
Parameters:
- `WIDTH`, 256, pixels per row (>= 3)
- `HEIGHT`, 256, rows per frame (>= 3)
- `BITW`, 8, pixel width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  pixel present on `in_pixel`
- `in_pixel`  in  BITW  raster-order input pixel
- `in_ready`  out  1  block accepts a pixel this cycle; handshake = `in_valid & in_ready`
- `win_valid`  out  1  window outputs valid this cycle
- `border`  out  1  centre lies on row 0, row HEIGHT-1, column 0 or column WIDTH-1
- `u00..u22`  out  BITW each  window, `uRC`, where R is the row offset (0 = top) and C is the column offset (0 = left)
- `out_row`  out  $clog2(HEIGHT)  centre row of the current window
- `out_col`  out  $clog2(WIDTH)  centre column of the current window
- `frame_done`  out  1  one-cycle pulse coinciding with the last window of the frame

## Operation
- Storage: line buffers `lb1` (previous row) and `lb2` (row before that), WIDTH x BITW each; plus a 3x3 register window built from three column registers.
- Input counter `in_col`/`in_row` tracks the position of the accepted pixel.
- On each accepted pixel at column c:
  - read `top=lb2[c]` and `mid=lb1[c]`
  - write `lb2[c]<=lb1[c]` and `lb1[c]<=in_pixel`
  - shift the window left; the new right column is {top, mid, in_pixel}
- Window after input index i (= row*WIDTH+col) is centred at index i-WIDTH-1.
- FSM:
  - FILL (reset state): `in_ready=1`. Accept pixels with no output. After accepting index WIDTH, go to RUN.
  - RUN: `in_ready=1`. Every accepted pixel produces one window the next cycle. Accepting index WIDTH*HEIGHT-1 goes to FLUSH.
  - FLUSH: `in_ready=0`. Emit WIDTH+1 windows on consecutive cycles with no input; all have `border=1`. After the last one (`frame_done=1`), clear counters and line-buffer pointers and return to FILL.
- Windows with `border=1` drive `u00..u22=0`. This masks row-wrap garbage at columns 0/1 and unwritten line-buffer contents in rows 0/1.
- Output centre counter `out_row`/`out_col` advances by one per emitted window and wraps the column at WIDTH-1.
- No output backpressure: the downstream stage is combinational and always consumes.
- Line buffers are not cleared between frames. Contents from a previous frame are only ever seen in border windows, which are masked to 0.

## Timing
- Reset (async assert, sync-release usage): state=FILL, counters=0, `in_ready=1`, `win_valid=0`, `border=0`, `u00..u22=0`, `out_row=out_col=0`, `frame_done=0`.
- Latency: a window for centre k is registered on the clock edge that accepts input index k+WIDTH+1 and is visible the following cycle.
- Inter-frame behaviour:
  - First output of a frame appears 1 cycle after the (WIDTH+2)-th accepted pixel.
  - FLUSH takes WIDTH+1 cycles; `in_ready` is low throughout.
  - A new frame's first pixel can be accepted in the cycle after `frame_done`.
- Input bubbles (`in_valid=0`) in FILL or RUN: `win_valid=0` that cycle and no state change.
- `in_valid` while `in_ready=0` is ignored. The pixel must be held by the source.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and the next accepted pixel is treated as (0,0).
- Output count per frame is exactly WIDTH*HEIGHT windows. Interior windows number (WIDTH-2)*(HEIGHT-2).

## Test plan
- Ramp frame, WIDTH=HEIGHT=8, pixel = row*8+col, continuous valid:
  - first `win_valid` 1 cycle after the 10th pixel, with centre (0,0), `border=1`, all u=0
  - centre (1,1) gives u00..u22 = 0,1,2,8,9,10,16,17,18, `border=0`
- Count check, 256x256 continuous input:
  - exactly 65536 `win_valid` cycles, 64516 of them with `border=0`
  - `frame_done` on the window with `out_row=255`, `out_col=255`
  - `in_ready` low for exactly 257 cycles
- Random `in_valid` bubbles (50%) on the 8x8 ramp: window contents and order identical to the continuous run. `win_valid` occurs only the cycle after a handshake in RUN.
- Two back-to-back frames (ramp then all-0xFF), 8x8:
  - second frame's interior windows all 0xFF
  - its border windows all 0, even though the line buffers hold stale ramp data
- Reset pulse after 30 pixels of frame 1, then a full 8x8 ramp: output matches the clean ramp run exactly, and `out_row`/`out_col` restart at 0.
- SobelX end-to-end with `conv3x3_comb`, 8x8 frame with left half 0 and right half 200: the output PGM column at the vertical edge matches the golden `y`, and every border pixel is 0.
